// File: rtl/csa_digit_serial_adder_pkg.sv
// Purpose : shared constants, FSM state encoding and sizing helper for the digit-serial adder.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: SLICE_W (slice width), csa_state_t (IDLE/RUN/DONE), idx_width().
package csa_pkg;

  // Width of one digit; matches the 4-bit carry_skip_adder slice.
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } csa_state_t;

  // Slice counter width: clog2 of the slice count, never narrower than one bit.
  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/csa_digit_serial_adder_if.sv
// Purpose : operand/result handshake bundle between producer, adder and consumer.
// Latency : n/a (wiring only).
// Backpressure: in_ready gates the operand side, out_ready gates the result side.
// Ports   : in_valid/in_ready/A/B/Cin (operand request), out_valid/out_ready/SUM/CARRY/OVF (result), busy.
interface csa_digit_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] SUM;
  logic             CARRY;
  logic             OVF;
  logic             busy;

  // Adder side.
  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, SUM, CARRY, OVF, busy
  );

  // Producer/consumer side.
  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, SUM, CARRY, OVF, busy
  );

endinterface

// File: rtl/csa_digit_serial_adder_slice.sv
// Purpose : 4-bit carry-skip adder slice, SUM = A + B + Cin, CARRY = carry-out.
// Latency : purely combinational.
// Backpressure: none.
// Ports   : A, B (4-bit), Cin -> SUM (4-bit), CARRY.
module carry_skip_adder
  import csa_pkg::*;
(
  input  logic [SLICE_W-1:0] A,
  input  logic [SLICE_W-1:0] B,
  input  logic               Cin,
  output logic [SLICE_W-1:0] SUM,
  output logic               CARRY
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  always_comb begin
    c    = '0;
    SUM  = '0;
    p    = A ^ B;
    c[0] = Cin;
    for (int i = 0; i < SLICE_W; i++) begin
      SUM[i]   = p[i] ^ c[i];
      c[i+1]   = (A[i] & B[i]) | (p[i] & c[i]);
    end
  end

  // When every bit propagates, the carry-in bypasses the ripple chain.
  // Functionally identical to c[SLICE_W]; it only shortens the carry path.
  assign CARRY = (&p) ? Cin : c[SLICE_W];

endmodule

// File: rtl/csa_digit_serial_adder.sv
// Purpose : WIDTH-bit adder built from one 4-bit carry-skip slice, iterated LSB slice first.
// Latency : result valid NSLICE cycles after the operand handshake; one result per NSLICE+2 cycles.
// Backpressure: in_ready only in IDLE; result held bit-exact in DONE until out_ready.
// Ports   : clk, rst_n (async active-low), bus (csa_digit_serial_adder_if.slave).
module csa_digit_serial_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  csa_digit_serial_adder_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDXW   = idx_width(NSLICE);

  localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  generate
    if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_width_check
      $error("csa_digit_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  logic [1:0]         state;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cy_r;     // carry chained between slices
  logic [IDXW-1:0]    idx;
  logic               carry_r;  // final carry-out presented to the consumer
  logic               ovf_r;

  logic [SLICE_W-1:0] s_a;
  logic [SLICE_W-1:0] s_b;
  logic [SLICE_W-1:0] s_sum;
  logic               s_cy;

  // Slice select: the only logic in front of the adder each cycle.
  assign s_a = a_r[SLICE_W*idx +: SLICE_W];
  assign s_b = b_r[SLICE_W*idx +: SLICE_W];

  carry_skip_adder u_slice (
    .A     (s_a),
    .B     (s_b),
    .Cin   (cy_r),
    .SUM   (s_sum),
    .CARRY (s_cy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      cy_r    <= 1'b0;
      idx     <= '0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_r   <= bus.A;
            b_r   <= bus.B;
            cy_r  <= bus.Cin;
            sum_r <= '0;
            idx   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sum_r[SLICE_W*idx +: SLICE_W] <= s_sum;
          cy_r <= s_cy;
          idx  <= idx + 1'b1;
          if (idx == LAST) begin
            carry_r <= s_cy;
            // The last slice produces the result MSB, so OVF can be taken
            // straight from the slice output on this same edge.
            ovf_r   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                       (s_sum[SLICE_W-1] != a_r[WIDTH-1]);
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pure decodes of the state register: no combinational path from
  // in_valid to in_ready or from out_ready to out_valid.
  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.SUM       = sum_r;
  assign bus.CARRY     = carry_r;
  assign bus.OVF       = ovf_r;

endmodule

// File: tb/tb_csa_digit_serial_adder.sv
// Purpose : directed and randomized self-checking bench for csa_digit_serial_adder (WIDTH=16).
// Latency : expects out_valid 4 cycles after the operand handshake.
// Backpressure: exercises out_ready stalls in DONE and in_valid held during busy.
module tb_csa_digit_serial_adder;

  logic clk;
  logic rst_n;

  int total;
  int bad;

  csa_digit_serial_adder_if #(.WIDTH(16)) bus ();

  csa_digit_serial_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {OVF, CARRY, SUM} from the arithmetic definition.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] t;
    logic        ovf;
    t   = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    ovf = (a[15] == b[15]) && (t[15] != a[15]);
    return {ovf, t[16], t[15:0]};
  endfunction

  // Present operands and return just after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin);
    int n;
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = cin;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      step();
      n++;
    end
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      step();
      lat++;
    end
  endtask

  task automatic run_txn(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    send(a, b, cin);
    wait_valid(lat);
    check({nm, "_lat"},   32'(lat),           32'd4);
    check({nm, "_sum"},   32'(bus.SUM),       32'(es));
    check({nm, "_carry"}, 32'(bus.CARRY),     32'(ec));
    check({nm, "_ovf"},   32'(bus.OVF),       32'(eo));
    check({nm, "_inrdy"}, 32'(bus.in_ready),  32'd0);
    check({nm, "_busy"},  32'(bus.busy),      32'd1);
    bus.out_ready = 1'b1;
    step();
    check({nm, "_vld_drop"}, 32'(bus.out_valid), 32'd0);
    check({nm, "_rdy_back"}, 32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b0;
  endtask

  logic [17:0] exp_q[$];

  task automatic producer();
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    int          n;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) step();
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom_range(0, 1));
      bus.A        = a;
      bus.B        = b;
      bus.Cin      = cin;
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 200) begin
        step();
        n++;
      end
      if (!bus.in_ready) begin
        check("rnd_accept", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        break;
      end
      exp_q.push_back(model(a, b, cin));
      step();
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic consumer();
    int          got;
    int          cyc;
    logic [17:0] e;
    got = 0;
    cyc = 0;
    while (got < 200 && cyc < 20000) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected", 32'(bus.out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rnd_sum",   32'(bus.SUM),   32'(e[15:0]));
          check("rnd_carry", 32'(bus.CARRY), 32'(e[16]));
          check("rnd_ovf",   32'(bus.OVF),   32'(e[17]));
        end
        got++;
      end
      step();
      cyc++;
    end
    bus.out_ready = 1'b0;
    check("rnd_count", 32'(got), 32'd200);
  endtask

  initial begin
    int lat;
    int seen;
    total = 0;
    bad   = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Cin       = 1'b0;

    #12;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_sum",       32'(bus.SUM),       32'd0);
    check("rst_carry",     32'(bus.CARRY),     32'd0);
    check("rst_ovf",       32'(bus.OVF),       32'd0);
    #10;
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // out_ready high ahead of out_valid must be harmless.
    bus.out_ready = 1'b1;
    run_txn("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_txn("t2", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_txn("t3", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_txn("t4", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Abort after two RUN edges: slices 0,1 of AAAA+5555 are already 0xFF.
    send(16'hAAAA, 16'h5555, 1'b0);
    step();
    step();
    check("mid_partial_sum", 32'(bus.SUM), 32'h00FF);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready",  32'(bus.in_ready),  32'd1);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_busy",      32'(bus.busy),      32'd0);
    check("arst_sum",       32'(bus.SUM),       32'd0);
    check("arst_carry",     32'(bus.CARRY),     32'd0);
    check("arst_ovf",       32'(bus.OVF),       32'd0);
    #2;
    rst_n = 1'b1;
    step();
    check("arst_rel_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) seen++;
      step();
    end
    check("arst_no_valid", 32'(seen), 32'd0);

    // Backpressure: hold DONE for 6 cycles while new operands wait.
    send(16'h1111, 16'h2222, 1'b1);
    wait_valid(lat);
    check("bp_lat", 32'(lat), 32'd4);
    bus.A        = 16'h0F0F;
    bus.B        = 16'h0101;
    bus.Cin      = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("bp_sum",   32'(bus.SUM),       32'h3334);
      check("bp_carry", 32'(bus.CARRY),     32'd0);
      check("bp_ovf",   32'(bus.OVF),       32'd0);
      check("bp_inrdy", 32'(bus.in_ready),  32'd0);
      check("bp_vld",   32'(bus.out_valid), 32'd1);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    check("bp_release_vld",   32'(bus.out_valid), 32'd0);
    check("bp_release_inrdy", 32'(bus.in_ready),  32'd1);
    step();
    bus.in_valid = 1'b0;
    check("bp_new_taken", 32'(bus.busy), 32'd1);
    wait_valid(lat);
    check("bp2_lat",   32'(lat),       32'd4);
    check("bp2_sum",   32'(bus.SUM),   32'h1010);
    check("bp2_carry", 32'(bus.CARRY), 32'd0);
    check("bp2_ovf",   32'(bus.OVF),   32'd0);
    step();
    bus.out_ready = 1'b0;
    check("bp2_idle", 32'(bus.in_ready), 32'd1);

    fork
      producer();
      consumer();
    join
    check("rnd_leftover", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
